// File: rtl/serial_sub_pkg.sv
//==============================================================================
// Module   : serial_sub_pkg
// Purpose  : Shared state encoding and default width for the bit-serial
//            subtractor controller.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/full_sub_bit.sv
//==============================================================================
// Module   : full_sub_bit
// Purpose  : Single-bit full subtractor cell, a - b - bin.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module full_sub_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic borrow
);

  assign diff   = a ^ b ^ bin;
  assign borrow = (~a & b) | (~a & bin) | (b & bin);

endmodule

`default_nettype wire

// File: rtl/serial_sub_ctrl.sv
//==============================================================================
// Module   : serial_sub_ctrl
// Purpose  : Bit-serial WIDTH-bit subtractor; one full_sub_bit cell reused
//            LSB first, one bit per clock, with start/done handshake.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out
);

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res;
  logic             r_brw;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff;
  logic             w_borrow;
  logic             w_last;
  logic [WIDTH-1:0] w_res_nxt;

  full_sub_bit u_cell (
    .a      (r_a_sr[0]),
    .b      (r_b_sr[0]),
    .bin    (r_brw),
    .diff   (w_diff),
    .borrow (w_borrow)
  );

  assign w_last    = (r_cnt == c_cnt_last);
  // Each new diff bit enters at the MSB so the LSB ends up at bit 0 after WIDTH shifts.
  assign w_res_nxt = {w_diff, r_res[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    ready       = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (abort)       w_state_nxt = ST_IDLE;
        else if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr     <= '0;
      r_b_sr     <= '0;
      r_res      <= '0;
      r_brw      <= 1'b0;
      r_cnt      <= '0;
      diff_out   <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a_sr <= a_in;
            r_b_sr <= b_in;
            r_brw  <= bin_in;
            r_cnt  <= '0;
          end
        end
        ST_RUN: begin
          if (abort) begin
            r_cnt <= '0;
          end else begin
            r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
            r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
            r_res  <= w_res_nxt;
            r_brw  <= w_borrow;
            if (w_last) begin
              // Results are published only once the whole word is complete.
              diff_out   <= w_res_nxt;
              borrow_out <= w_borrow;
              r_cnt      <= '0;
            end else begin
              r_cnt <= r_cnt + c_cnt_one;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_sub_ctrl.sv
//==============================================================================
// Module   : tb_serial_sub_ctrl
// Purpose  : Self-checking bench for serial_sub_ctrl (WIDTH=8).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_serial_sub_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             bin_in;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff_out;
  logic             borrow_out;

  int n_vec;
  int n_err;

  serial_sub_ctrl #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .a_in       (a_in),
    .b_in       (b_in),
    .bin_in     (bin_in),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .diff_out   (diff_out),
    .borrow_out (borrow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic [WIDTH-1:0] exp_diff;
    logic             exp_borrow;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: plain (WIDTH+1)-bit unsigned subtraction; top bit is the borrow.
  function automatic logic [WIDTH:0] ref_sub(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic bi);
    logic [WIDTH:0] r;
    r = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bi};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!ready && n < 20) begin
      tick();
      n++;
    end
    if (!ready) check("ready_wait", {31'd0, ready}, 32'd1);
  endtask

  // Accepts one operation, then waits (bounded) for done; lat = edges from accept to done.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bi,
                        output logic [WIDTH-1:0] d, output logic bo, output int lat);
    wait_ready();
    a_in = a; b_in = b; bin_in = bi; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      tick();
      lat++;
      check("onehot", {31'd0, $onehot({ready, busy, done})}, 32'd1);
    end
    if (!done) check("done_timeout", {31'd0, done}, 32'd1);
    d  = diff_out;
    bo = borrow_out;
  endtask

  initial begin
    logic [WIDTH-1:0] d;
    logic             bo;
    logic [WIDTH:0]   exp;
    logic [WIDTH-1:0] ra, rb, d_first;
    logic             rbi;
    int               lat, n_done, done_edge;

    n_vec = 0; n_err = 0;
    start = 0; abort = 0; a_in = '0; b_in = '0; bin_in = 0;

    tbl[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
    tbl[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl[3] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0};
    tbl[4] = '{8'h80, 8'h00, 1'b0, 8'h80, 1'b0};

    rst_n = 1'b0;
    #17;
    check("rst_ready",  {31'd0, ready},      32'd1);
    check("rst_busy",   {31'd0, busy},       32'd0);
    check("rst_done",   {31'd0, done},       32'd0);
    check("rst_diff",   {24'd0, diff_out},   32'd0);
    check("rst_borrow", {31'd0, borrow_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed table
    for (int i = 0; i < 5; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].bin, d, bo, lat);
      check("tbl_diff",    {24'd0, d},  {24'd0, tbl[i].exp_diff});
      check("tbl_borrow",  {31'd0, bo}, {31'd0, tbl[i].exp_borrow});
      check("tbl_latency", lat,         WIDTH);
      tick();
      check("tbl_ready_after", {31'd0, ready},    32'd1);
      check("tbl_done_pulse",  {31'd0, done},     32'd0);
      check("tbl_diff_hold",   {24'd0, diff_out}, {24'd0, tbl[i].exp_diff});
    end

    // start pulses during RUN (edge k+3) and DONE (edge k+9) are ignored
    wait_ready();
    a_in = 8'h33; b_in = 8'h11; bin_in = 0; start = 1;
    tick();
    start = 0;
    n_done = 0; done_edge = -1; d_first = '0;
    for (int e = 1; e <= 12; e++) begin
      if (e == 3 || e == 9) begin
        a_in = 8'h01; b_in = 8'h02; bin_in = 1; start = 1;
      end
      tick();
      start = 0;
      if (done) begin
        n_done++;
        done_edge = e;
        d_first = diff_out;
      end
    end
    check("ign_done_count", n_done,           1);
    check("ign_done_edge",  done_edge,        WIDTH);
    check("ign_diff",       {24'd0, d_first}, 32'h22);
    check("ign_not_queued", {31'd0, busy},    32'd0);
    check("ign_ready",      {31'd0, ready},   32'd1);

    // abort at edge k+4 keeps the previous result
    run_op(8'h5A, 8'h3C, 1'b0, d, bo, lat);
    check("pre_abort_diff", {24'd0, d}, 32'h1E);
    tick();
    wait_ready();
    a_in = 8'hC3; b_in = 8'h42; bin_in = 1; start = 1;
    tick();
    start = 0;
    repeat (3) tick();
    abort = 1;
    tick();
    abort = 0;
    check("abort_busy",  {31'd0, busy},  32'd0);
    check("abort_ready", {31'd0, ready}, 32'd1);
    n_done = 0;
    for (int e = 0; e < 12; e++) begin
      tick();
      if (done) n_done++;
    end
    check("abort_no_done",  n_done,                0);
    check("abort_diff",     {24'd0, diff_out},     32'h1E);
    check("abort_borrow",   {31'd0, borrow_out},   32'd0);
    run_op(8'hC3, 8'h42, 1'b1, d, bo, lat);
    check("post_abort_diff",   {24'd0, d},  32'h80);
    check("post_abort_borrow", {31'd0, bo}, 32'd0);
    tick();

    // asynchronous reset during RUN
    wait_ready();
    a_in = 8'h12; b_in = 8'h34; bin_in = 0; start = 1;
    tick();
    start = 0;
    repeat (4) tick();
    rst_n = 0;
    #1;
    check("mid_rst_ready",  {31'd0, ready},      32'd1);
    check("mid_rst_busy",   {31'd0, busy},       32'd0);
    check("mid_rst_done",   {31'd0, done},       32'd0);
    check("mid_rst_diff",   {24'd0, diff_out},   32'd0);
    check("mid_rst_borrow", {31'd0, borrow_out}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    n_done = 0;
    for (int e = 0; e < 12; e++) begin
      tick();
      if (done) n_done++;
    end
    check("rst_rel_no_done", n_done,          0);
    check("rst_rel_ready",   {31'd0, ready},  32'd1);
    run_op(8'h12, 8'h34, 1'b0, d, bo, lat);
    check("post_rst_diff",   {24'd0, d},  32'hDE);
    check("post_rst_borrow", {31'd0, bo}, 32'd1);
    tick();

    // Random sweep against the arithmetic reference
    for (int i = 0; i < 1000; i++) begin
      ra  = WIDTH'($urandom);
      rb  = WIDTH'($urandom);
      rbi = 1'($urandom);
      exp = ref_sub(ra, rb, rbi);
      run_op(ra, rb, rbi, d, bo, lat);
      check("rnd_result",  {23'd0, bo, d}, {23'd0, exp});
      check("rnd_latency", lat,            WIDTH);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
